// File: rtl/risc_dec_stage.sv
// RV32I decode stage: registered output bundle plus one skid entry, flush,
// illegal-instruction detection and a saturating illegal counter.
module risc_dec_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XLEN-1:0]  instr_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [6:0]       op_o,
    output logic [4:0]       rd_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [2:0]       funct3_o,
    output logic [6:0]       funct7_o,
    output logic [XLEN-1:0]  imm_o,
    output logic             rd_we_o,
    output logic             rs1_used_o,
    output logic             rs2_used_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("risc_dec_stage supports XLEN=32 only");
    end

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUIMM = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUREG = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm;
        logic            rd_we;
        logic            rs1_used;
        logic            rs2_used;
        logic            illegal;
    } bundle_t;

    bundle_t         dec_c, out_q, out_d, skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            legal_c, writes_c, accept_c, load_c;
    logic [2:0]      f3_c;
    logic [6:0]      f7_c;

    assign f3_c = instr_i[14:12];
    assign f7_c = instr_i[31:25];

    // Combinational decode of the incoming instruction into a bundle
    always_comb begin
        dec_c    = '0;
        legal_c  = 1'b0;
        writes_c = 1'b0;
        dec_c.pc = pc_i;
        dec_c.op = instr_i[6:0];
        case (instr_i[6:0])
            OP_ALUREG: begin
                legal_c = (f7_c == 7'h00) ||
                          (f7_c == 7'h20 && (f3_c == 3'b000 || f3_c == 3'b101));
                dec_c.rs1 = instr_i[19:15];
                dec_c.rs2 = instr_i[24:20];
                dec_c.f3  = f3_c;
                dec_c.f7  = f7_c;
                dec_c.rs1_used = 1'b1;
                dec_c.rs2_used = 1'b1;
                writes_c  = 1'b1;
            end
            OP_LOAD, OP_ALUIMM, OP_JALR: begin
                if (instr_i[6:0] == OP_LOAD)
                    legal_c = !(f3_c == 3'b011 || f3_c == 3'b110 || f3_c == 3'b111);
                else if (instr_i[6:0] == OP_JALR)
                    legal_c = (f3_c == 3'b000);
                else if (f3_c == 3'b001)
                    legal_c = (f7_c == 7'h00);
                else if (f3_c == 3'b101)
                    legal_c = (f7_c == 7'h00 || f7_c == 7'h20);
                else
                    legal_c = 1'b1;
                // Shift-immediates carry their funct7 in the upper immediate bits
                if (instr_i[6:0] == OP_ALUIMM && (f3_c == 3'b001 || f3_c == 3'b101))
                    dec_c.f7 = f7_c;
                dec_c.rs1 = instr_i[19:15];
                dec_c.f3  = f3_c;
                dec_c.imm = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
                dec_c.rs1_used = 1'b1;
                writes_c  = 1'b1;
            end
            OP_STORE: begin
                legal_c   = (f3_c < 3'b011);
                dec_c.rs1 = instr_i[19:15];
                dec_c.rs2 = instr_i[24:20];
                dec_c.f3  = f3_c;
                dec_c.imm = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                dec_c.rs1_used = 1'b1;
                dec_c.rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                legal_c   = !(f3_c == 3'b010 || f3_c == 3'b011);
                dec_c.rs1 = instr_i[19:15];
                dec_c.rs2 = instr_i[24:20];
                dec_c.f3  = f3_c;
                dec_c.imm = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                             instr_i[30:25], instr_i[11:8], 1'b0};
                dec_c.rs1_used = 1'b1;
                dec_c.rs2_used = 1'b1;
            end
            OP_JAL: begin
                legal_c   = 1'b1;
                dec_c.imm = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                             instr_i[20], instr_i[30:21], 1'b0};
                writes_c  = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                legal_c   = 1'b1;
                dec_c.imm = {instr_i[31:12], 12'b0};
                writes_c  = 1'b1;
            end
            default: legal_c = 1'b0;
        endcase
        if (writes_c) dec_c.rd = instr_i[11:7];
        dec_c.rd_we = writes_c && (instr_i[11:7] != 5'd0);
        if (!(legal_c && instr_i[1:0] == 2'b11)) begin
            dec_c         = '0;
            dec_c.pc      = pc_i;
            dec_c.op      = instr_i[6:0];
            dec_c.illegal = 1'b1;
        end
    end

    // Next-state: output register, skid entry, ready and counter
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;
        accept_c     = in_valid_i && in_ready_q;
        load_c       = !out_valid_q || out_ready_i;
        if (out_valid_q && out_ready_i && out_q.illegal && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (load_c) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_c) begin
                out_d       = dec_c;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            skid_d       = dec_c;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign pc_o          = out_q.pc;
    assign op_o          = out_q.op;
    assign rd_o          = out_q.rd;
    assign rs1_o         = out_q.rs1;
    assign rs2_o         = out_q.rs2;
    assign funct3_o      = out_q.f3;
    assign funct7_o      = out_q.f7;
    assign imm_o         = out_q.imm;
    assign rd_we_o       = out_q.rd_we;
    assign rs1_used_o    = out_q.rs1_used;
    assign rs2_used_o    = out_q.rs2_used;
    assign illegal_o     = out_q.illegal;
    assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_risc_dec_stage.sv
// Bench for risc_dec_stage: decode vector table, back-pressure/flush/saturation
// sequences and random traffic against a FIFO reference model.
module tb_risc_dec_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        we;
        logic        u1;
        logic        u2;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        we;
        logic        u1;
        logic        u2;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr, pc_in;
    logic        in_ready, out_valid, rd_we, rs1_used, rs2_used, illegal;
    logic [31:0] pc_o, imm_o;
    logic [6:0]  op_o, funct7_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o;
    logic [15:0] cnt;

    logic        in_ready2, out_valid2, rd_we2, rs1_used2, rs2_used2, illegal2;
    logic [31:0] pc_o2, imm_o2;
    logic [6:0]  op_o2, funct7_o2;
    logic [4:0]  rd_o2, rs1_o2, rs2_o2;
    logic [2:0]  funct3_o2;
    logic [1:0]  cnt2;

    always #5 clk = ~clk;

    risc_dec_stage u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .instr_i(instr), .pc_i(pc_in),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .pc_o(pc_o),
        .op_o(op_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .funct3_o(funct3_o), .funct7_o(funct7_o), .imm_o(imm_o),
        .rd_we_o(rd_we), .rs1_used_o(rs1_used), .rs2_used_o(rs2_used),
        .illegal_o(illegal), .illegal_cnt_o(cnt)
    );

    risc_dec_stage #(.CNT_W(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready2), .instr_i(instr), .pc_i(pc_in),
        .out_valid_o(out_valid2), .out_ready_i(out_ready), .pc_o(pc_o2),
        .op_o(op_o2), .rd_o(rd_o2), .rs1_o(rs1_o2), .rs2_o(rs2_o2),
        .funct3_o(funct3_o2), .funct7_o(funct7_o2), .imm_o(imm_o2),
        .rd_we_o(rd_we2), .rs1_used_o(rs1_used2), .rs2_used_o(rs2_used2),
        .illegal_o(illegal2), .illegal_cnt_o(cnt2)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic [31:0] consumed[$];
    int unsigned mcnt, mcnt2;
    logic        fired;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference decode, organised by instruction format
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        byte         fmt;
        logic        ok;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          sx, v;
        f3 = ins[14:12];
        f7 = ins[31:25];
        sx = int'(ins);
        fmt = "-";
        ok = 1'b0;
        case (ins[6:0])
            7'h33: begin fmt = "R"; ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); end
            7'h03: begin fmt = "I"; ok = !(f3 inside {3'd3, 3'd6, 3'd7}); end
            7'h13: begin
                fmt = "I";
                ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
            end
            7'h67: begin fmt = "I"; ok = (f3 == 0); end
            7'h23: begin fmt = "S"; ok = (f3 < 3); end
            7'h63: begin fmt = "B"; ok = !(f3 inside {3'd2, 3'd3}); end
            7'h6F: begin fmt = "J"; ok = 1'b1; end
            7'h37, 7'h17: begin fmt = "U"; ok = 1'b1; end
            default: ok = 1'b0;
        endcase
        e = '0;
        e.pc = pc;
        e.op = ins[6:0];
        if (!ok) begin
            e.ill = 1'b1;
            return e;
        end
        if (fmt inside {"R", "I", "S", "B"}) begin e.rs1 = ins[19:15]; e.u1 = 1'b1; end
        if (fmt inside {"R", "S", "B"})      begin e.rs2 = ins[24:20]; e.u2 = 1'b1; end
        if (fmt inside {"R", "I", "J", "U"}) begin e.rd = ins[11:7]; e.we = (ins[11:7] != 0); end
        if (!(fmt inside {"J", "U"})) e.f3 = f3;
        if (fmt == "R" || (ins[6:0] == 7'h13 && (f3 == 1 || f3 == 5))) e.f7 = f7;
        case (fmt)
            "I": v = sx >>> 20;
            "S": v = ((sx >>> 25) * 32) + int'(ins[11:7]);
            "B": v = ((sx >>> 31) * 4096) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                     + int'(ins[11:8]) * 2;
            "J": v = ((sx >>> 31) * 1048576) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                     + int'(ins[30:21]) * 2;
            "U": v = sx & 32'hFFFF_F000;
            default: v = 0;
        endcase
        e.imm = 32'(v);
        return e;
    endfunction

    function automatic exp_t got_bundle();
        return {pc_o, op_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, imm_o,
                rd_we, rs1_used, rs2_used, illegal};
    endfunction

    task automatic check_state();
        chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
        chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
        chk("illegal_cnt", 128'(cnt), 128'(mcnt));
        chk("illegal_cnt_w2", 128'(cnt2), 128'(mcnt2));
        if (q.size() > 0) chk("bundle", 128'(got_bundle()), 128'(q[0]));
    endtask

    // One clock: drive inputs at negedge, advance model, sample next negedge
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, output logic acc);
        exp_t e;
        in_valid  = v;
        instr     = ins;
        pc_in     = pc;
        out_ready = rdy;
        flush     = fl;
        acc   = v && (q.size() < 2);
        fired = 1'b0;
        if (q.size() > 0 && rdy) begin
            e = q.pop_front();
            consumed.push_back(e.pc);
            fired = 1'b1;
            if (e.ill) begin
                if (mcnt < 65535) mcnt++;
                if (mcnt2 < 3) mcnt2++;
            end
        end
        if (fl) q.delete();
        else if (acc) q.push_back(ref_dec(ins, pc));
        @(negedge clk);
        check_state();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        instr = '0; pc_in = '0;
        @(negedge clk);
        @(negedge clk);
        q.delete();
        consumed.delete();
        mcnt = 0;
        mcnt2 = 0;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_bundle", 128'(got_bundle()), 128'(0));
        chk("rst_cnt", 128'(cnt), 128'(0));
        rst_n = 1'b1;
    endtask

    vec_t        vecs[$];
    logic [6:0]  ops[9];
    logic        acc;
    logic [1:0]  sat_obs[$];
    logic [1:0]  sat_exp[5];

    initial begin
        vecs.push_back('{32'hFFF00293, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 1, 1, 0, 0});
        vecs.push_back('{32'h40315093, 7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'h00000403, 1, 1, 0, 0});
        vecs.push_back('{32'h40311093, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 0, 0, 0, 1});
        vecs.push_back('{32'hFE000EE3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 0, 1, 1, 0});
        vecs.push_back('{32'h12345537, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1, 0, 0, 0});
        vecs.push_back('{32'h008000EF, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000008, 1, 0, 0, 0});
        vecs.push_back('{32'h0063A623, 7'h23, 5'd0, 5'd7, 5'd6, 3'd2, 7'h00, 32'h0000000C, 0, 1, 1, 0});
        vecs.push_back('{32'h00000000, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 0, 0, 0, 1});
        vecs.push_back('{32'h402081B3, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 1, 1, 1, 0});
        vecs.push_back('{32'h00208033, 7'h33, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000000, 0, 1, 1, 0});
        vecs.push_back('{32'h0000B003, 7'h03, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 0, 0, 0, 1});
        vecs.push_back('{32'h00009067, 7'h67, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 0, 0, 0, 1});
        vecs.push_back('{32'hFFFFF117, 7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000, 1, 0, 0, 0});
        vecs.push_back('{32'h00000001, 7'h01, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 0, 0, 0, 1});
        ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        do_reset();

        // Decode table, streamed back to back with downstream always ready
        foreach (vecs[i]) begin
            exp_t te;
            te = {32'h1000 + 32'(i) * 4, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].f3, vecs[i].f7, vecs[i].imm, vecs[i].we, vecs[i].u1,
                  vecs[i].u2, vecs[i].ill};
            step(1'b1, vecs[i].instr, 32'h1000 + 32'(i) * 4, 1'b1, 1'b0, acc);
            chk($sformatf("vec%0d", i), 128'(got_bundle()), 128'(te));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Back-pressure: three stalled cycles, then drain in order
        do_reset();
        step(1'b1, 32'hFFF00293, 32'h100, 1'b0, 1'b0, acc);
        step(1'b1, 32'h40315093, 32'h104, 1'b0, 1'b0, acc);
        chk("bp_in_ready_low", 128'(in_ready), 128'(0));
        step(1'b1, 32'h402081B3, 32'h108, 1'b0, 1'b0, acc);
        chk("bp_first_held", 128'(pc_o), 128'(32'h100));
        begin
            logic [31:0] pend[$];
            pend = '{32'h108, 32'h10C};
            for (int c = 0; c < 20; c++) begin
                if (pend.size() > 0) begin
                    step(1'b1, 32'h0063A623, pend[0], 1'b1, 1'b0, acc);
                    if (acc) void'(pend.pop_front());
                end else begin
                    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
                end
            end
            chk("bp_pending_sent", 128'(pend.size()), 128'(0));
        end
        chk("bp_count", 128'(consumed.size()), 128'(4));
        if (consumed.size() == 4)
            chk("bp_order", 128'({consumed[0], consumed[1], consumed[2], consumed[3]}),
                128'({32'h100, 32'h104, 32'h108, 32'h10C}));

        // Flush with skid full and input valid
        do_reset();
        step(1'b1, 32'hFFF00293, 32'h200, 1'b0, 1'b0, acc);
        step(1'b1, 32'hFFF00293, 32'h204, 1'b0, 1'b0, acc);
        step(1'b1, 32'hFFF00293, 32'h208, 1'b0, 1'b1, acc);
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_in_ready", 128'(in_ready), 128'(1));
        for (int c = 0; c < 4; c++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        chk("flush_none_emitted", 128'(consumed.size()), 128'(0));

        // Saturation of the 2-bit counter over five illegal bundles
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(k < 5, 32'h0, 32'h300 + 32'(k) * 4, 1'b1, 1'b0, acc);
            if (fired) sat_obs.push_back(cnt2);
        end
        chk("sat_len", 128'(sat_obs.size()), 128'(5));
        foreach (sat_obs[k])
            if (k < 5) chk($sformatf("sat%0d", k), 128'(sat_obs[k]), 128'(sat_exp[k]));

        // Random traffic, then a reset with work still in flight
        do_reset();
        for (int c = 0; c < 800; c++) begin
            logic [31:0] r, ins;
            r = $urandom();
            if ($urandom_range(0, 3) == 0) ins = r;
            else ins = {r[31:7], ops[$urandom_range(0, 8)]};
            step($urandom_range(0, 3) != 0, ins, $urandom(), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 39) == 0, acc);
        end
        step(1'b1, 32'hFFF00293, 32'h400, 1'b0, 1'b0, acc);
        step(1'b1, 32'hFFF00293, 32'h404, 1'b0, 1'b0, acc);
        do_reset();
        for (int c = 0; c < 3; c++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
